// File: rtl/ceyloniac_mem_pkg.sv
// Shared types and defaults for the ceyloniac sync-RAM initiator.
// FSM encoding, default widths, response buffer depth, burst-length helper.
package ceyloniac_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int RSP_DEPTH      = 2;

  // cmd_len encodes beats minus one
  function automatic int len_to_beats(input int len);
    return len + 1;
  endfunction

endpackage

// File: rtl/ceyloniac_rsp_fifo2.sv
// Purpose: 2-entry response buffer carrying {last, data} with occupancy count.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push when full is dropped and pop when empty is ignored; the caller prevents both.
module ceyloniac_rsp_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok    = pop && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/ceyloniac_ram_master.sv
// Purpose: turns write/read burst commands into sync-RAM strobe cycles and buffers read beats.
// Latency: write beat hits the RAM in its accept cycle; first read beat is valid 2 edges after command accept.
// Backpressure: wdata stalls by withholding wdata_valid; reads stop issuing while buffer + in-flight would exceed 2.
module ceyloniac_ram_master
  import ceyloniac_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  ram_enable,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH:0]   head;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  pop;
  logic                  last_beat;
  logic [2:0]            occ_next;

  assign last_beat = (beat_cnt == len_q);
  assign pop       = rsp_valid && rsp_ready;
  // Counting this cycle's pop keeps reads streaming at one beat per cycle
  assign occ_next  = 3'(buf_count) + 3'(inflight) - 3'(pop);

  assign cmd_ready   = !reset && (state == ST_IDLE);
  assign wdata_ready = !reset && (state == ST_WRITE);
  assign wr_fire     = wdata_ready && wdata_valid;
  assign rd_issue    = !reset && (state == ST_READ) && (occ_next < 3'(RSP_DEPTH));

  assign ram_enable       = wr_fire || rd_issue;
  assign ram_write_enable = wr_fire;
  assign ram_read_enable  = rd_issue;
  assign ram_addr         = ram_enable ? addr_cnt : '0;
  assign ram_write_data   = wr_fire ? wdata : '0;

  assign rsp_valid = !reset && (buf_count != 2'd0);
  assign rsp_data  = rsp_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rsp_last  = rsp_valid && head[DATA_WIDTH];
  assign busy      = !reset && ((state != ST_IDLE) || (buf_count != 2'd0) || inflight);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr_cnt      <= '0;
      beat_cnt      <= '0;
      len_q         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && last_beat;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_cnt <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            state    <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          if (wr_fire || rd_issue) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            if (last_beat) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ceyloniac_rsp_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_last, ram_read_data}),
    .pop       (pop),
    .head_data (head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_ceyloniac_ram_master.sv
// Directed bench for ceyloniac_ram_master with a behavioural sync RAM behind it.
module tb_ceyloniac_ram_master;
  import ceyloniac_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid, rsp_ready, rsp_last, busy;
  logic [DW-1:0] rsp_data;
  logic          ram_enable, ram_write_enable, ram_read_enable;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data, ram_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ceyloniac_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy),
    .ram_enable(ram_enable), .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write_enable) mem[ram_addr] <= ram_write_data;
      if (ram_read_enable)  ram_read_data <= mem[ram_addr];
    end
  end

  int            cyc = 0, rsp_n = 0, rd_pulses = 0, acc_cyc = 0, excl_err = 0, idle_err = 0;
  logic [DW:0]   rsp_log [0:255];
  int            rsp_cyc [0:255];
  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rsp_log[rsp_n[7:0]] <= {rsp_last, rsp_data};
      rsp_cyc[rsp_n[7:0]] <= cyc;
      rsp_n <= rsp_n + 1;
    end
    if (ram_read_enable) rd_pulses <= rd_pulses + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (ram_write_enable && ram_read_enable) excl_err <= excl_err + 1;
    if (!ram_enable && (ram_addr != '0 || ram_write_data != '0)) idle_err <= idle_err + 1;
    cyc <= cyc + 1;
  end

  // Presents a command and returns at the negedge after acceptance with cmd_valid dropped
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit got = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (cmd_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready never seen for addr=%h", a);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (!busy) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %b after 200 cycles", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    #1; checks++;
    if ({cmd_ready, wdata_ready, rsp_valid, rsp_last, busy, ram_enable, ram_write_enable,
         ram_read_enable} !== 8'd0 || ram_addr !== '0 || ram_write_data !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_rdy=%b busy=%b en=%b addr=%h want all zero",
               cmd_ready, busy, ram_enable, ram_addr);
    end
    @(negedge clk); reset = 1'b0;
    #1; checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_burst();
    int base;
    send_cmd(1'b1, 16'h0000, 8'd3);
    for (int k = 0; k < 4; k++) begin
      wdata_valid = 1'b1; wdata = 32'(k);
      #1; checks++;
      if ({ram_enable, ram_write_enable, ram_read_enable, wdata_ready} !== 4'b1101 ||
          ram_addr !== 16'(k) || ram_write_data !== 32'(k)) begin
        errors++;
        $display("FAIL wr_beat%0d: en/we/re/rdy=%b%b%b%b addr=%h data=%h want 1101 %h %h", k,
                 ram_enable, ram_write_enable, ram_read_enable, wdata_ready, ram_addr, ram_write_data, k, k);
      end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1; checks++;
    if (cmd_ready !== 1'b1 || ram_enable !== 1'b0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL wr_done: cmd_ready=%b en=%b addr=%h want 1 0 0", cmd_ready, ram_enable, ram_addr);
    end
    rsp_ready = 1'b1; base = rsp_n;
    send_cmd(1'b0, 16'h0002, 8'd0);
    wait_idle();
    checks++;
    if (rsp_n - base != 1 || rsp_log[base] !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL wr_readback: n=%0d beat=%h want 1 %h", rsp_n - base, rsp_log[base], {1'b1, 32'd2});
    end
  endtask

  task automatic test_read_burst();
    int base;
    logic [DW:0] e;
    rsp_ready = 1'b1; base = rsp_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0000; cmd_len = 8'd3;
    #1; checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rd_accept: cmd_ready=%b want 1", cmd_ready);
    end
    @(negedge clk); cmd_valid = 1'b0;
    #1; checks++;
    if (rsp_valid !== 1'b0 || ram_read_enable !== 1'b1 || ram_write_enable !== 1'b0 || ram_addr !== 16'h0000) begin
      errors++;
      $display("FAIL rd_issue0: rsp_valid=%b re=%b we=%b addr=%h want 0 1 0 0000",
               rsp_valid, ram_read_enable, ram_write_enable, ram_addr);
    end
    @(negedge clk); #1; checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_early: rsp_valid=%b one edge after issue want 0", rsp_valid);
    end
    @(negedge clk); #1; checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL rd_first: rsp_valid=%b data=%h last=%b want 1 0 0", rsp_valid, rsp_data, rsp_last);
    end
    wait_idle();
    checks++;
    if (rsp_n - base != len_to_beats(3) || rsp_cyc[base] != acc_cyc + 3) begin
      errors++;
      $display("FAIL rd_count_lat: n=%0d first_pop=%0d want %0d %0d", rsp_n - base, rsp_cyc[base],
               len_to_beats(3), acc_cyc + 3);
    end
    for (int k = 0; k < 4; k++) begin
      e = {(k == 3), 32'(k)};
      checks++;
      if (rsp_log[base + k] !== e || rsp_cyc[base + k] != rsp_cyc[base] + k) begin
        errors++;
        $display("FAIL rd_beat%0d: got %h at cyc %0d want %h at cyc %0d", k, rsp_log[base + k],
                 rsp_cyc[base + k], e, rsp_cyc[base] + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, pb;
    logic [DW:0] e;
    rsp_ready = 1'b0; base = rsp_n; pb = rd_pulses;
    send_cmd(1'b0, 16'h0000, 8'd3);
    repeat (10) @(negedge clk);
    #1; checks++;
    if (rd_pulses - pb != 2 || rsp_valid !== 1'b1 || rsp_data !== 32'd0 || busy !== 1'b1 || rsp_n != base) begin
      errors++;
      $display("FAIL bp_stall: pulses=%0d rsp_valid=%b data=%h busy=%b popped=%0d want 2 1 0 1 0",
               rd_pulses - pb, rsp_valid, rsp_data, busy, rsp_n - base);
    end
    rsp_ready = 1'b1;
    wait_idle();
    checks++;
    if (rsp_n - base != 4 || rd_pulses - pb != 4) begin
      errors++;
      $display("FAIL bp_total: beats=%0d pulses=%0d want 4 4", rsp_n - base, rd_pulses - pb);
    end
    for (int k = 0; k < 4; k++) begin
      e = {(k == 3), 32'(k)};
      checks++;
      if (rsp_log[base + k] !== e) begin
        errors++; $display("FAIL bp_beat%0d: got %h want %h", k, rsp_log[base + k], e);
      end
    end
  endtask

  task automatic test_addr_wrap();
    int base;
    logic [AW-1:0] exp_addr [3];
    logic [DW:0]   e;
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000};
    send_cmd(1'b1, 16'hFFFE, 8'd2);
    for (int k = 0; k < 3; k++) begin
      wdata_valid = 1'b1; wdata = 32'hA + 32'(k);
      #1; checks++;
      if (ram_write_enable !== 1'b1 || ram_addr !== exp_addr[k]) begin
        errors++;
        $display("FAIL wrap_addr%0d: we=%b addr=%h want 1 %h", k, ram_write_enable, ram_addr, exp_addr[k]);
      end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    rsp_ready = 1'b1; base = rsp_n;
    send_cmd(1'b0, 16'hFFFE, 8'd2);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      e = {(k == 2), 32'hA + 32'(k)};
      checks++;
      if (rsp_n - base != 3 || rsp_log[base + k] !== e) begin
        errors++;
        $display("FAIL wrap_read%0d: n=%0d got %h want 3 %h", k, rsp_n - base, rsp_log[base + k], e);
      end
    end
  endtask

  task automatic test_wdata_bubbles();
    int base, k;
    logic [DW:0] e;
    k = 0;
    send_cmd(1'b1, 16'h0100, 8'd3);
    for (int c = 0; c < 7; c++) begin
      wdata_valid = (c % 2 == 0); wdata = 32'h5000 + 32'(k);
      #1; checks++;
      if (wdata_valid) begin
        if (ram_write_enable !== 1'b1 || ram_addr !== 16'h0100 + 16'(k) || ram_write_data !== 32'h5000 + 32'(k)) begin
          errors++;
          $display("FAIL bub_beat%0d: we=%b addr=%h data=%h want 1 %h %h", k, ram_write_enable,
                   ram_addr, ram_write_data, 16'h0100 + 16'(k), 32'h5000 + 32'(k));
        end
      end else if (ram_enable !== 1'b0 || ram_addr !== '0 || wdata_ready !== 1'b1) begin
        errors++;
        $display("FAIL bub_gap%0d: en=%b addr=%h rdy=%b want 0 0000 1", c, ram_enable, ram_addr, wdata_ready);
      end
      @(negedge clk);
      if (c % 2 == 0) k++;
    end
    wdata_valid = 1'b0;
    #1; checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bub_done: cmd_ready=%b after 4 beats want 1", cmd_ready);
    end
    rsp_ready = 1'b1; base = rsp_n;
    send_cmd(1'b0, 16'h0100, 8'd3);
    wait_idle();
    for (int j = 0; j < 4; j++) begin
      e = {(j == 3), 32'h5000 + 32'(j)};
      checks++;
      if (rsp_log[base + j] !== e) begin
        errors++; $display("FAIL bub_read%0d: got %h want %h", j, rsp_log[base + j], e);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int base;
    rsp_ready = 1'b1; base = rsp_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_len = 8'd7;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1; checks++;
    if ({cmd_ready, wdata_ready, rsp_valid, rsp_last, busy, ram_enable, ram_write_enable,
         ram_read_enable} !== 8'd0 || ram_addr !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: cmd_rdy=%b rsp_valid=%b busy=%b en=%b addr=%h want all zero",
               cmd_ready, rsp_valid, busy, ram_enable, ram_addr);
    end
    @(negedge clk); reset = 1'b0;
    #1; checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: cmd_ready=%b rsp_valid=%b busy=%b want 1 0 0", cmd_ready, rsp_valid, busy);
    end
    repeat (3) @(negedge clk);
    #1; checks++;
    if (rsp_valid !== 1'b0 || rsp_n != base) begin
      errors++;
      $display("FAIL rst_mid_drain: rsp_valid=%b beats=%0d want 0 0", rsp_valid, rsp_n - base);
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (excl_err != 0 || idle_err != 0) begin
      errors++;
      $display("FAIL strobe_rules: both_enables=%0d idle_nonzero=%0d want 0 0", excl_err, idle_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_addr_wrap();
    test_wdata_bubbles();
    test_reset_mid_burst();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
